// File: rtl/centroid_tracker.sv
// centroid_tracker
//   Consumes one centroid measurement per camera frame, rejects weak or
//   out-of-range strobes, gates outliers against the current filtered
//   position, smooths accepted positions with a shift-based EMA and runs a
//   SEARCH/ACQUIRE/TRACK lock state machine for the overlay cursor.
//
// Handshake: c_valid is a one-cycle strobe with no back-pressure (there is
//   no ready); c_x/c_y/white_count are only looked at while it is high.
//   pos_valid is a one-cycle pulse on the cycle after an accepted load or
//   update, when pos_x/pos_y already carry the new value.
//
// Ports:
//   clk          system clock
//   reset        synchronous active-high reset
//   c_valid      measurement strobe
//   c_x, c_y     measured centroid column / row
//   white_count  pixel count behind the measurement
//   frame_tick   end-of-frame pulse
//   pos_x, pos_y filtered position, integer part
//   pos_valid    position-updated pulse
//   locked       high in TRACK
//   state        debug state: 0=SEARCH, 1=ACQUIRE, 2=TRACK
module centroid_tracker #(
  parameter int H_MAX       = 1024,
  parameter int V_MAX       = 768,
  parameter int MIN_COUNT   = 64,
  parameter int GATE        = 48,
  parameter int SHIFT       = 2,
  parameter int ACQ_FRAMES  = 4,
  parameter int LOST_FRAMES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        c_valid,
  input  logic [10:0] c_x,
  input  logic [9:0]  c_y,
  input  logic [19:0] white_count,
  input  logic        frame_tick,
  output logic [10:0] pos_x,
  output logic [9:0]  pos_y,
  output logic        pos_valid,
  output logic        locked,
  output logic [1:0]  state
);

  localparam int FXW = 11 + SHIFT;
  localparam int FYW = 10 + SHIFT;
  localparam int AW  = $clog2(ACQ_FRAMES + 1);
  localparam int MW  = $clog2(LOST_FRAMES + 1);

  localparam logic [11:0]        H_LIM   = 12'(H_MAX);
  localparam logic [10:0]        V_LIM   = 11'(V_MAX);
  localparam logic [20:0]        MIN_LIM = 21'(MIN_COUNT);
  localparam logic signed [11:0] GATE_S  = 12'(GATE);

  typedef enum logic [1:0] {
    S_SEARCH  = 2'd0,
    S_ACQUIRE = 2'd1,
    S_TRACK   = 2'd2
  } st_t;

  st_t st_q, st_d;

  logic [FXW-1:0] fx_q;
  logic [FYW-1:0] fy_q;
  logic [AW-1:0]  acq_cnt;
  logic [MW-1:0]  miss_cnt;
  logic           got_meas;
  logic           pos_valid_q;

  // ---------------- measurement qualification ----------------
  logic acc, in_gate, counted, do_load, do_update, miss_limit, acq_done;
  logic signed [11:0] dx, dy, adx, ady;

  assign acc = c_valid && ({1'b0, white_count} >= MIN_LIM) &&
               ({1'b0, c_x} < H_LIM) && ({1'b0, c_y} < V_LIM);

  // Integer-part distance in 12-bit signed arithmetic; both operands are
  // zero-extended so the subtraction cannot wrap.
  assign dx  = $signed({1'b0, c_x}) - $signed({1'b0, pos_x});
  assign dy  = $signed({2'b00, c_y}) - $signed({2'b00, pos_y});
  assign adx = (dx < 0) ? -dx : dx;
  assign ady = (dy < 0) ? -dy : dy;
  assign in_gate = (adx <= GATE_S) && (ady <= GATE_S);

  // An out-of-gate measurement in TRACK is thrown away and does not count
  // as having seen the target this frame; everywhere else it does.
  assign counted    = acc && ((st_q != S_TRACK) || in_gate);
  assign do_load    = acc && ((st_q == S_SEARCH) || ((st_q == S_ACQUIRE) && !in_gate));
  assign do_update  = acc && in_gate && (st_q != S_SEARCH);
  assign miss_limit = (miss_cnt == MW'(LOST_FRAMES));
  assign acq_done   = ((acq_cnt + AW'(1)) == AW'(ACQ_FRAMES));

  // ---------------- EMA filter arithmetic ----------------
  // f + (((m << SHIFT) - f) >>> SHIFT) with one guard bit so the difference
  // keeps its sign; the result stays within the range of m.
  logic [FXW-1:0]        fx_load, fx_upd;
  logic [FYW-1:0]        fy_load, fy_upd;
  logic signed [FXW:0]   fx_diff, fx_step, fx_sum;
  logic signed [FYW:0]   fy_diff, fy_step, fy_sum;

  assign fx_load = FXW'(c_x) << SHIFT;
  assign fy_load = FYW'(c_y) << SHIFT;
  assign fx_diff = $signed({1'b0, fx_load}) - $signed({1'b0, fx_q});
  assign fy_diff = $signed({1'b0, fy_load}) - $signed({1'b0, fy_q});
  assign fx_step = fx_diff >>> SHIFT;
  assign fy_step = fy_diff >>> SHIFT;
  assign fx_sum  = $signed({1'b0, fx_q}) + fx_step;
  assign fy_sum  = $signed({1'b0, fy_q}) + fy_step;
  assign fx_upd  = fx_sum[FXW-1:0];
  assign fy_upd  = fy_sum[FYW-1:0];

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (reset) st_q <= S_SEARCH;
    else       st_q <= st_d;
  end

  // ---------------- FSM: next state ----------------
  // A counted measurement always beats the miss limit.
  always_comb begin
    st_d = st_q;
    case (st_q)
      S_SEARCH: begin
        if (acc) st_d = S_ACQUIRE;
      end
      S_ACQUIRE: begin
        if (acc && in_gate && acq_done) st_d = S_TRACK;
        else if (acc)                   st_d = S_ACQUIRE;
        else if (miss_limit)            st_d = S_SEARCH;
      end
      S_TRACK: begin
        if (!counted && miss_limit) st_d = S_SEARCH;
      end
      default: st_d = S_SEARCH;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    locked = (st_q == S_TRACK);
    state  = st_q;
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      fx_q        <= '0;
      fy_q        <= '0;
      acq_cnt     <= '0;
      miss_cnt    <= '0;
      got_meas    <= 1'b0;
      pos_valid_q <= 1'b0;
    end else begin
      pos_valid_q <= do_load || do_update;

      if (do_load) begin
        fx_q    <= fx_load;
        fy_q    <= fy_load;
        acq_cnt <= AW'(1);
      end else if (do_update) begin
        fx_q <= fx_upd;
        fy_q <= fy_upd;
        if (st_q == S_ACQUIRE) acq_cnt <= acq_cnt + AW'(1);
      end else if (st_d == S_SEARCH) begin
        acq_cnt <= '0;
      end

      // Misses only accumulate while acquiring or tracking.
      if ((st_q == S_SEARCH) || (st_d == S_SEARCH) || counted)
        miss_cnt <= '0;
      else if (frame_tick && !got_meas && !miss_limit)
        miss_cnt <= miss_cnt + MW'(1);

      if (frame_tick)   got_meas <= 1'b0;
      else if (counted) got_meas <= 1'b1;
    end
  end

  assign pos_x     = fx_q[FXW-1:SHIFT];
  assign pos_y     = fy_q[FYW-1:SHIFT];
  assign pos_valid = pos_valid_q;

endmodule

// File: tb/tb_centroid_tracker.sv
// tb_centroid_tracker
//   Directed bench for centroid_tracker: a per-cycle vector table covering
//   reset, load, reload, EMA steps, rejection and gate boundaries, followed
//   by hand-written multi-frame sequences for lock, loss and same-cycle
//   measurement/frame_tick behaviour.
module tb_centroid_tracker;

  logic        clk;
  logic        reset;
  logic        c_valid;
  logic [10:0] c_x;
  logic [9:0]  c_y;
  logic [19:0] white_count;
  logic        frame_tick;
  logic [10:0] pos_x;
  logic [9:0]  pos_y;
  logic        pos_valid;
  logic        locked;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  centroid_tracker dut (
    .clk         (clk),
    .reset       (reset),
    .c_valid     (c_valid),
    .c_x         (c_x),
    .c_y         (c_y),
    .white_count (white_count),
    .frame_tick  (frame_tick),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .pos_valid   (pos_valid),
    .locked      (locked),
    .state       (state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst;
    logic        cv;
    logic [10:0] cx;
    logic [9:0]  cy;
    logic [19:0] wc;
    logic        ft;
    logic [10:0] ex;
    logic [9:0]  ey;
    logic        epv;
    logic [1:0]  est;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  function automatic vec_t mk(input int rst, input int cv, input int cx, input int cy,
                              input int wc, input int ft, input int ex, input int ey,
                              input int epv, input int est);
    vec_t v;
    v.rst = 1'(rst);  v.cv = 1'(cv);   v.cx = 11'(cx); v.cy = 10'(cy);
    v.wc  = 20'(wc);  v.ft = 1'(ft);   v.ex = 11'(ex); v.ey = 10'(ey);
    v.epv = 1'(epv);  v.est = 2'(est);
    return v;
  endfunction

  // ---------------- driver / checker tasks ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int ex, input int ey,
                         input int epv, input int est);
    chk({tag, ".pos_x"},     int'(pos_x),     ex);
    chk({tag, ".pos_y"},     int'(pos_y),     ey);
    chk({tag, ".pos_valid"}, int'(pos_valid), epv);
    chk({tag, ".state"},     int'(state),     est);
    chk({tag, ".locked"},    int'(locked),    (est == 2) ? 1 : 0);
  endtask

  // Drive one cycle of inputs, clock it in, sample #1 after the edge.
  task automatic cyc(input int cv, input int x, input int y, input int wc, input int ft);
    c_valid     = 1'(cv);
    c_x         = 11'(x);
    c_y         = 10'(y);
    white_count = 20'(wc);
    frame_tick  = 1'(ft);
    @(posedge clk);
    #1;
    c_valid    = 1'b0;
    frame_tick = 1'b0;
  endtask

  task automatic tick();
    cyc(0, 0, 0, 0, 1);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1; c_valid = 1'b0; c_x = '0; c_y = '0;
    white_count = '0; frame_tick = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    //            rst cv  cx    cy   wc   ft  ex   ey  pv st
    vecs[0]  = mk(1, 0,    0,   0,   0, 0,   0,   0, 0, 0);
    vecs[1]  = mk(0, 0,    0,   0,   0, 0,   0,   0, 0, 0);
    vecs[2]  = mk(0, 1,  100, 100,  64, 0, 100, 100, 1, 1); // load, MIN_COUNT edge
    vecs[3]  = mk(0, 0,    0,   0,   0, 0, 100, 100, 0, 1);
    vecs[4]  = mk(0, 1,  200, 100, 100, 0, 200, 100, 1, 1); // out of gate -> reload
    vecs[5]  = mk(0, 1,  100, 100, 100, 0, 100, 100, 1, 1); // reload again
    vecs[6]  = mk(0, 1,  140, 100, 100, 0, 110, 100, 1, 1); // f 400->440
    vecs[7]  = mk(0, 1,  140, 100, 100, 0, 117, 100, 1, 1); // 440->470
    vecs[8]  = mk(0, 1,  140, 100, 100, 0, 123, 100, 1, 2); // 470->492, 4th meas
    vecs[9]  = mk(0, 1,  140, 100, 100, 0, 127, 100, 1, 2); // 492->509
    vecs[10] = mk(0, 1,  127, 100,  63, 0, 127, 100, 0, 2); // weak
    vecs[11] = mk(0, 1, 1024, 100, 100, 0, 127, 100, 0, 2); // x out of range
    vecs[12] = mk(0, 1,  127, 768, 100, 0, 127, 100, 0, 2); // y out of range
    vecs[13] = mk(0, 1,  176, 100, 100, 0, 127, 100, 0, 2); // dx=+49 discarded
    vecs[14] = mk(0, 1,  175, 100, 100, 0, 139, 100, 1, 2); // dx=+48: 509->556
    vecs[15] = mk(0, 1,  139, 148, 100, 0, 139, 112, 1, 2); // dy=+48: 400->448
    vecs[16] = mk(0, 1,  139,  63, 100, 0, 139, 112, 0, 2); // dy=-49 discarded
    vecs[17] = mk(0, 1,   91, 112, 100, 0, 127, 112, 1, 2); // dx=-48: 556->508
    vecs[18] = mk(1, 1,  300, 200, 100, 1,   0,   0, 0, 0); // reset mid-TRACK wins
    vecs[19] = mk(0, 1,  300, 200, 100, 0, 300, 200, 1, 1); // direct load
    vecs[20] = mk(0, 0,    0,   0,   0, 1, 300, 200, 0, 1); // measured frame ends

    for (int i = 0; i < NV; i++) begin
      reset = vecs[i].rst;
      cyc(int'(vecs[i].cv), int'(vecs[i].cx), int'(vecs[i].cy),
          int'(vecs[i].wc), int'(vecs[i].ft));
      reset = 1'b0;
      chk_out($sformatf("vec%0d", i), int'(vecs[i].ex), int'(vecs[i].ey),
              int'(vecs[i].epv), int'(vecs[i].est));
    end

    // ACQUIRE -> TRACK with measurement and frame_tick in the same cycle.
    for (int i = 0; i < 3; i++) begin
      cyc(1, 300, 200, 100, 1);
      chk_out($sformatf("acq%0d", i), 300, 200, 1, (i < 2) ? 1 : 2);
    end

    // 20 frames of same-cycle measurement + frame_tick: never a miss.
    for (int i = 0; i < 20; i++) begin
      cyc(1, 300, 200, 100, 1);
      chk_out($sformatf("same_cyc%0d", i), 300, 200, 1, 2);
      idle();
      chk($sformatf("same_cyc%0d.pv_low", i), int'(pos_valid), 0);
    end
    // Miss counter must have stayed at 0: seven empty frames keep lock.
    repeat (7) tick();
    chk_out("same_cyc.after7", 300, 200, 0, 2);
    tick();
    idle();
    chk_out("same_cyc.lost", 300, 200, 0, 0);

    // Re-acquire at the range corner, then lose lock on rejected strobes.
    cyc(1, 1023, 767, 64, 1);
    chk_out("corner.load", 1023, 767, 1, 1);
    repeat (3) cyc(1, 1023, 767, 64, 1);
    chk_out("corner.track", 1023, 767, 1, 2);
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) cyc(1, 1023, 767, 63, 0);
      else            cyc(1, 1024, 767, 100, 0);
      chk($sformatf("reject%0d.pv", i), int'(pos_valid), 0);
      tick();
      if (i == 6) chk_out("reject.after7", 1023, 767, 0, 2);
    end
    idle();
    chk_out("reject.lost", 1023, 767, 0, 0);

    // Single out-of-gate measurement in TRACK, then seven empty frames.
    repeat (4) cyc(1, 500, 400, 100, 1);
    chk_out("gate.track", 500, 400, 1, 2);
    cyc(1, 549, 400, 100, 0);
    chk_out("gate.discard", 500, 400, 0, 2);
    tick();
    repeat (6) tick();
    chk_out("gate.after7", 500, 400, 0, 2);
    tick();
    idle();
    chk_out("gate.lost", 500, 400, 0, 0);

    // ACQUIRE times out back to SEARCH after LOST_FRAMES empty frames.
    cyc(1, 10, 10, 100, 1);
    chk_out("acq_to.load", 10, 10, 1, 1);
    repeat (7) tick();
    chk_out("acq_to.after7", 10, 10, 0, 1);
    tick();
    idle();
    chk_out("acq_to.lost", 10, 10, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
